cpu6_ifetch: RTL

CPU6_IFETCH -- requirements
Module: cpu6_ifetch

---
 rtl/cpu6_ifetch_pkg.sv | 19 +
 rtl/cpu6_ifetch_buf.sv | 37 +++
 rtl/cpu6_ifetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu6_ifetch_pkg.sv
// Shared widths, NOP encoding and fetch FSM state encodings for the cpu6 instruction fetch unit.
package cpu6_ifetch_pkg;

  localparam int CPU6_XLEN = 32;
  localparam logic [CPU6_XLEN-1:0] CPU6_NOP = 32'h0000_0013;

  localparam logic [1:0] CPU6_IFSTATE_IDLE  = 2'd0;
  localparam logic [1:0] CPU6_IFSTATE_REQ   = 2'd1;
  localparam logic [1:0] CPU6_IFSTATE_WAIT  = 2'd2;
  localparam logic [1:0] CPU6_IFSTATE_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IFS_IDLE  = CPU6_IFSTATE_IDLE,
    IFS_REQ   = CPU6_IFSTATE_REQ,
    IFS_WAIT  = CPU6_IFSTATE_WAIT,
    IFS_DRAIN = CPU6_IFSTATE_DRAIN
  } ifstate_e;

endpackage

// File: rtl/cpu6_ifetch_buf.sv
// One-entry fetch buffer {tag, data, valid}; only instantiated when CPU6_IFETCH_BUF_EN is defined.
module cpu6_ifetch_buf
  import cpu6_ifetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CPU6_XLEN-1:0] lookup_addr_i,
  output logic                 hit_o,
  output logic [CPU6_XLEN-1:0] data_o,
  input  logic                 wr_en_i,
  input  logic [CPU6_XLEN-1:0] wr_addr_i,
  input  logic [CPU6_XLEN-1:0] wr_data_i,
  input  logic                 inval_i
);

  logic [CPU6_XLEN-1:0] tag_q;
  logic [CPU6_XLEN-1:0] data_q;
  logic                 valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q   <= '0;
      data_q  <= CPU6_NOP;
      valid_q <= 1'b0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      tag_q   <= wr_addr_i;
      data_q  <= wr_data_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (lookup_addr_i == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/cpu6_ifetch.sv
// cpu6 instruction fetch unit: single-outstanding bus fetch FSM with flush draining.
// Optional one-entry hit buffer enabled by defining CPU6_IFETCH_BUF_EN.
//
// state | meaning
// IDLE  | sample fetchaddr: fault misaligned, serve buffer hit, or latch address
// REQ   | ibus_req held with addr_q until granted
// WAIT  | granted, waiting for the response
// DRAIN | flushed after grant, swallow one response
module cpu6_ifetch
  import cpu6_ifetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CPU6_XLEN-1:0] fetchaddr,
  input  logic                 flush,
  output logic [CPU6_XLEN-1:0] instr,
  output logic                 instr_valid,
  output logic                 stall,
  output logic                 fault,
  output logic                 ibus_req,
  output logic [CPU6_XLEN-1:0] ibus_addr,
  input  logic                 ibus_gnt,
  input  logic                 ibus_rvalid,
  input  logic [CPU6_XLEN-1:0] ibus_rdata,
  input  logic                 ibus_err
);

  ifstate_e             state_q, state_d;
  logic [CPU6_XLEN-1:0] addr_q, addr_d;
  logic [CPU6_XLEN-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 fault_q, fault_d;
  logic                 flush_seen_q, flush_seen_d;
  logic                 buf_hit;
  logic [CPU6_XLEN-1:0] buf_data;

`ifdef CPU6_IFETCH_BUF_EN
  logic buf_wr;
  logic buf_inval;

  assign buf_wr    = (state_q == IFS_WAIT) && ibus_rvalid && !flush && !ibus_err;
  assign buf_inval = ((state_q == IFS_WAIT) || (state_q == IFS_DRAIN)) && ibus_rvalid && ibus_err;

  cpu6_ifetch_buf u_buf (
    .clk           (clk),
    .reset         (reset),
    .lookup_addr_i (fetchaddr),
    .hit_o         (buf_hit),
    .data_o        (buf_data),
    .wr_en_i       (buf_wr),
    .wr_addr_i     (addr_q),
    .wr_data_i     (ibus_rdata),
    .inval_i       (buf_inval)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = CPU6_NOP;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    valid_d      = 1'b0;
    fault_d      = 1'b0;
    flush_seen_d = flush_seen_q;
    case (state_q)
      IFS_IDLE: begin
        if (fetchaddr[1:0] != 2'b00) begin
          instr_d = CPU6_NOP;
          valid_d = 1'b1;
          fault_d = 1'b1;
        end else if (buf_hit) begin
          instr_d = buf_data;
          valid_d = 1'b1;
        end else begin
          addr_d       = fetchaddr;
          flush_seen_d = 1'b0;
          state_d      = IFS_REQ;
        end
      end
      IFS_REQ: begin
        // The request cannot be withdrawn, so a flush is remembered until the grant.
        if (flush) flush_seen_d = 1'b1;
        if (ibus_gnt) state_d = (flush_seen_q || flush) ? IFS_DRAIN : IFS_WAIT;
      end
      IFS_WAIT: begin
        if (ibus_rvalid) begin
          state_d = IFS_IDLE;
          if (!flush) begin
            instr_d = ibus_err ? CPU6_NOP : ibus_rdata;
            valid_d = 1'b1;
            fault_d = ibus_err;
          end
        end else if (flush) begin
          state_d = IFS_DRAIN;
        end
      end
      IFS_DRAIN: begin
        if (ibus_rvalid) state_d = IFS_IDLE;
      end
      default: state_d = IFS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IFS_IDLE;
      addr_q       <= '0;
      instr_q      <= CPU6_NOP;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign stall       = ~valid_q;
  assign fault       = fault_q;
  assign ibus_req    = (state_q == IFS_REQ);
  assign ibus_addr   = addr_q;

endmodule
